warp_xdiv_iter: RTL and testbench

Parametrised iterative integer divider for the warp scalar integer cluster; successor to the fixed 64-bit divider interface. Produces quotient and remainder for RISC-V div/divu/rem/remu and their word forms. Adds a configurable datapath width, a configurable number of radix-2 steps per cycle, fast completion for special cases, shorter word-mode latency, and an abort input. Sits beside the single-cycle arithmetic and logic units and feeds writeback through a valid pulse carrying the destination register.

---
 rtl/warp_xdiv_iter.sv | 168 ++++++++++++++++
 tb/tb_warp_xdiv_iter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/warp_xdiv_iter.sv
// Iterative radix-2 restoring divider for div/divu/rem/remu and their word forms.
// STEPS chained step slices per cycle; divide-by-zero and signed overflow finish in one edge.

module warp_xdiv_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] rem_n,
    output logic [XLEN-1:0] q_n
);
    logic [XLEN:0] sh, diff;

    // The shifted partial remainder stays below 2*d, so one extra bit holds it.
    assign sh    = {rem, q[XLEN-1]};
    assign diff  = sh - {1'b0, d};
    assign rem_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    assign q_n   = {q[XLEN-2:0], ~diff[XLEN]};
endmodule

module warp_xdiv_iter #(
    parameter int XLEN  = 64,
    parameter int STEPS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_input_valid,
    output logic            o_input_ready,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_unsigned,
    input  logic            i_word,
    input  logic [4:0]      i_rd,
    input  logic            i_kill,
    output logic            o_valid,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic [4:0]      o_rd
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

    typedef struct packed {
        logic       wmode;
        logic       neg_q;
        logic       neg_r;
        logic [4:0] rd;
    } ctl_t;

    state_t          state, state_nx;
    ctl_t            ctl;
    logic [XLEN-1:0] rem_r, q_r, d_r;
    logic [CW-1:0]   cnt;

    logic            wmode, sa, sb, div0, ovf, accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg;
    logic [XLEN-1:0] rem_last, q_last;

    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sx);
        logic [XLEN-1:0] r;
        r = XLEN'(x[31:0]);
        if (sx) r = XLEN'($signed(x[31:0]));
        return r;
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] x, input logic wm);
        return wm ? ext32(x, 1'b1) : x;
    endfunction

    // Request decode: word-mode operands become 32-bit values extended to XLEN.
    assign wmode   = (XLEN == 64) && i_word;
    assign a_ext   = wmode ? ext32(i_op1, !i_unsigned) : i_op1;
    assign b_ext   = wmode ? ext32(i_op2, !i_unsigned) : i_op2;
    assign sa      = !i_unsigned && a_ext[XLEN-1];
    assign sb      = !i_unsigned && b_ext[XLEN-1];
    assign mag_a   = sa ? (XLEN'(0) - a_ext) : a_ext;
    assign mag_b   = sb ? (XLEN'(0) - b_ext) : b_ext;
    assign min_neg = wmode ? ext32(XLEN'(32'h8000_0000), 1'b1) : (XLEN'(1) << (XLEN - 1));
    assign div0    = (b_ext == '0);
    assign ovf     = !i_unsigned && (a_ext == min_neg) && (b_ext == '1);
    assign accept  = (state == IDLE) && i_input_valid && !i_kill;

    assign o_input_ready = (state == IDLE) && !i_rst;

    // Step slices chained combinationally; each generate scope owns its own wires.
    for (genvar s = 0; s < STEPS; s++) begin : g_step
        logic [XLEN-1:0] rem_i, q_i, rem_o, q_o;
        if (s == 0) begin : g_first
            assign rem_i = rem_r;
            assign q_i   = q_r;
        end else begin : g_next
            assign rem_i = g_step[s-1].rem_o;
            assign q_i   = g_step[s-1].q_o;
        end
        warp_xdiv_step #(.XLEN(XLEN)) u_step (
            .rem   (rem_i),
            .q     (q_i),
            .d     (d_r),
            .rem_n (rem_o),
            .q_n   (q_o)
        );
    end

    assign rem_last = g_step[STEPS-1].rem_o;
    assign q_last   = g_step[STEPS-1].q_o;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (i_input_valid) state_nx = (div0 || ovf) ? FIXUP : ITER;
            ITER:    if (cnt == CW'(1)) state_nx = FIXUP;
            FIXUP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (i_kill) state_nx = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctl         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            d_r         <= '0;
            cnt         <= '0;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_rd        <= '0;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                ctl.wmode <= wmode;
                ctl.rd    <= i_rd;
                d_r       <= mag_b;
                if (div0 || ovf) begin
                    // Special results go straight to the fixup registers unsigned.
                    ctl.neg_q <= 1'b0;
                    ctl.neg_r <= 1'b0;
                    q_r       <= div0 ? '1 : a_ext;
                    rem_r     <= div0 ? a_ext : '0;
                end else begin
                    // Word dividends sit in the top half so the step always feeds from the MSB.
                    ctl.neg_q <= sa ^ sb;
                    ctl.neg_r <= sa;
                    q_r       <= wmode ? (mag_a << (XLEN - 32)) : mag_a;
                    rem_r     <= '0;
                    cnt       <= wmode ? CW'(32 / STEPS) : CW'(XLEN / STEPS);
                end
            end else if (!i_kill && state == ITER) begin
                rem_r <= rem_last;
                q_r   <= q_last;
                cnt   <= cnt - CW'(1);
            end else if (!i_kill && state == FIXUP) begin
                o_valid     <= 1'b1;
                o_quotient  <= fmt(ctl.neg_q ? (XLEN'(0) - q_r) : q_r, ctl.wmode);
                o_remainder <= fmt(ctl.neg_r ? (XLEN'(0) - rem_r) : rem_r, ctl.wmode);
                o_rd        <= ctl.rd;
            end
        end
    end
endmodule

// File: tb/tb_warp_xdiv_iter.sv
// Directed checks of warp_xdiv_iter: STEPS=1 and STEPS=4 instances at XLEN=64.

module tb_warp_xdiv_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv1, k1, uns1, w1, rdy1, v1;
    logic [63:0] a1, b1, q1, r1;
    logic [4:0]  rd1, ord1;
    logic        iv4, k4, uns4, w4, rdy4, v4;
    logic [63:0] a4, b4, q4, r4;
    logic [4:0]  rd4, ord4;

    int          errs = 0;
    int          checks = 0;
    logic [63:0] pq, pr;
    logic [4:0]  prd;
    int          lat;

    always #5 clk = ~clk;

    warp_xdiv_iter #(.XLEN(64), .STEPS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_input_valid(iv1), .o_input_ready(rdy1),
        .i_op1(a1), .i_op2(b1), .i_unsigned(uns1), .i_word(w1), .i_rd(rd1),
        .i_kill(k1), .o_valid(v1), .o_quotient(q1), .o_remainder(r1), .o_rd(ord1)
    );

    warp_xdiv_iter #(.XLEN(64), .STEPS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_input_valid(iv4), .o_input_ready(rdy4),
        .i_op1(a4), .i_op2(b4), .i_unsigned(uns4), .i_word(w4), .i_rd(rd4),
        .i_kill(k4), .o_valid(v4), .o_quotient(q4), .o_remainder(r4), .o_rd(ord4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges after the accept edge until o_valid is seen; -1 when the bound expires.
    task automatic wait_v(input bit sel, input int lim, output int n_out);
        n_out = -1;
        for (int n = 1; n <= lim; n++) begin
            @(posedge clk); #1;
            if ((sel ? v4 : v1) === 1'b1) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic run1(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic uns, input logic wd, input logic [4:0] rd,
                        input logic [63:0] eq, input logic [63:0] er, input int elat);
        int n;
        @(negedge clk);
        a1 = a; b1 = b; uns1 = uns; w1 = wd; rd1 = rd; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; rd1 = ~rd;
        chk({tag, "_busy"}, 64'(rdy1), 64'd0);
        wait_v(1'b0, 200, n);
        chk({tag, "_lat"}, 64'(n), 64'(elat));
        chk({tag, "_q"}, q1, eq);
        chk({tag, "_r"}, r1, er);
        chk({tag, "_rd"}, 64'(ord1), 64'(rd));
        chk({tag, "_rdy"}, 64'(rdy1), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(v1), 64'd0);
        pq = eq; pr = er; prd = rd;
    endtask

    initial begin
        rst = 1'b1;
        {iv1, k1, uns1, w1, iv4, k4, uns4, w4} = '0;
        a1 = '0; b1 = '0; rd1 = '0; a4 = '0; b4 = '0; rd4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(v1), 64'd0);
        chk("rst_q", q1, 64'd0);
        chk("rst_r", r1, 64'd0);
        chk("rst_rd", 64'(ord1), 64'd0);
        chk("rst_rdy", 64'(rdy1), 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("idle_rdy", 64'(rdy1), 64'd1);

        run1("u100_7", 64'd100, 64'd7, 1'b1, 1'b0, 5'd5, 64'd14, 64'd2, 65);
        run1("sm7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, 5'd6,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run1("s7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 5'd7,
             64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
        run1("div0", 64'd42, 64'd0, 1'b1, 1'b0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1);
        run1("ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5'd9,
             64'h8000_0000_0000_0000, 64'd0, 1);
        run1("w_u", 64'h1234_5678_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 5'd10,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
        run1("w_ovf", 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5'd11,
             64'hFFFF_FFFF_8000_0000, 64'd0, 1);
        run1("w_sm100_7", 64'hDEAD_0000_FFFF_FF9C, 64'h0BAD_0000_0000_0007, 1'b0, 1'b1, 5'd12,
             64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 33);

        // Kill at E10 of a 64-step divide.
        @(negedge clk);
        a1 = 64'd1000; b1 = 64'd3; uns1 = 1'b1; w1 = 1'b0; rd1 = 5'd20; iv1 = 1'b1;
        @(posedge clk); #1 iv1 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) k1 = 1'b1;
        @(posedge clk); #1 k1 = 1'b0;
        chk("kill_rdy", 64'(rdy1), 64'd1);
        wait_v(1'b0, 80, lat);
        chk("kill_noval", 64'(lat < 0), 64'd1);
        chk("kill_q", q1, pq);
        chk("kill_r", r1, pr);
        chk("kill_rd", 64'(ord1), 64'(prd));

        // Reset in the middle of ITER.
        @(negedge clk);
        a1 = 64'd100; b1 = 64'd7; rd1 = 5'd3; iv1 = 1'b1;
        @(posedge clk); #1 iv1 = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("mrst_q", q1, 64'd0);
        chk("mrst_r", r1, 64'd0);
        chk("mrst_rd", 64'(ord1), 64'd0);
        chk("mrst_rdy", 64'(rdy1), 64'd0);
        @(negedge clk) rst = 1'b0;
        wait_v(1'b0, 80, lat);
        chk("mrst_noval", 64'(lat < 0), 64'd1);

        // Request presented together with kill is dropped.
        @(negedge clk);
        a1 = 64'd5; b1 = 64'd1; iv1 = 1'b1; k1 = 1'b1;
        @(posedge clk); #1 iv1 = 1'b0; k1 = 1'b0;
        chk("kreq_rdy", 64'(rdy1), 64'd1);
        wait_v(1'b0, 70, lat);
        chk("kreq_noval", 64'(lat < 0), 64'd1);
        chk("kreq_q", q1, 64'd0);

        // STEPS=4 back-to-back with the second request held valid.
        @(negedge clk);
        a4 = 64'd1000; b4 = 64'd10; uns4 = 1'b1; w4 = 1'b0; rd4 = 5'd1; iv4 = 1'b1;
        @(posedge clk); #1;
        chk("s4_busy", 64'(rdy4), 64'd0);
        @(negedge clk) begin a4 = 64'd99; b4 = 64'd9; rd4 = 5'd2; end
        wait_v(1'b1, 100, lat);
        chk("s4a_lat", 64'(lat), 64'd17);
        chk("s4a_q", q4, 64'd100);
        chk("s4a_r", r4, 64'd0);
        chk("s4a_rd", 64'(ord4), 64'd1);
        chk("s4a_rdy", 64'(rdy4), 64'd1);
        @(posedge clk); #1;
        chk("s4b_acc", 64'(rdy4), 64'd0);
        iv4 = 1'b0;
        wait_v(1'b1, 100, lat);
        chk("s4b_lat", 64'(lat), 64'd17);
        chk("s4b_q", q4, 64'd11);
        chk("s4b_r", r4, 64'd0);
        chk("s4b_rd", 64'(ord4), 64'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
